quadrature_decoder_counter: RTL and testbench

- Decodes a 2-phase quadrature pair (quad_a, quad_b) from an incremental encoder into up/down count steps.
- Drives an internal loadable, wrap-around position counter.
- Acts as the sensor-side front end that generates up_down/count-enable events for the team's up/down counter family.
- Also flags illegal phase transitions.

---
 rtl/qdec_pkg.sv | 26 ++
 rtl/qdec_sync_filter.sv | 48 ++++
 rtl/quadrature_decoder_counter.sv | 94 +++++++++
 tb/tb_quadrature_decoder_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared encodings for the quadrature decoder: phase codes, FSM states, filter depth.
package qdec_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_TRACK = 1'b1
  } qdec_state_t;

  localparam int FILTER_LEN = 3;

  // Successor of a phase in the up (A-leads-B) sequence 00->10->11->01->00.
  function automatic logic [1:0] phase_next_up(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// One encoder phase: SYNC_STAGES-flop synchronizer, plus a FILTER_LEN-sample
// stability filter when QDEC_GLITCH_FILTER_EN is defined.
module qdec_sync_filter
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  logic [FILTER_LEN-2:0] hist;
  logic                  filt_q;
  logic                  filt_d;
  logic                  stable;

  // The current sample plus FILTER_LEN-1 history samples must all agree.
  assign stable = (hist == {(FILTER_LEN-1){sync_out}});
  assign filt_d = stable ? sync_out : filt_q;
  assign dout   = filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= {hist[FILTER_LEN-3:0], sync_out};
      filt_q <= filt_d;
    end
  end
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/quadrature_decoder_counter.sv
// x4 quadrature decoder with loadable wrap-around position counter and sticky error flag.
// Optional input glitch filter: define QDEC_GLITCH_FILTER_EN.
module quadrature_decoder_counter
  import qdec_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             dir,
  output logic             step,
  output logic             err
);

  // PRIME spans the whole input pipeline so inputs already nonzero at reset
  // release reach prev before tracking starts, instead of looking like a jump.
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int PRIME_LEN = SYNC_STAGES + FILTER_LEN;
`else
  localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif
  localparam int PCW = $clog2(PRIME_LEN + 1);

  logic              a_f;
  logic              b_f;
  logic [1:0]        cur;
  logic [1:0]        prev;
  qdec_state_t       state;
  logic [PCW-1:0]    prime_cnt;
  logic              is_up;
  logic              is_down;
  logic              is_bad;

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .din   (quad_a),
    .dout  (a_f)
  );

  qdec_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .din   (quad_b),
    .dout  (b_f)
  );

  assign cur     = {a_f, b_f};
  assign is_up   = (cur == phase_next_up(prev));
  assign is_down = (prev == phase_next_up(cur));
  assign is_bad  = ((cur ^ prev) == 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      prev      <= PH_00;
      count_out <= '0;
      dir       <= 1'b1;
      step      <= 1'b0;
      err       <= 1'b0;
    end else begin
      step <= 1'b0;
      prev <= cur;
      if (err_clr) err <= 1'b0;
      case (state)
        ST_PRIME: begin
          if (prime_cnt == PCW'(PRIME_LEN - 1)) state <= ST_TRACK;
          else                                   prime_cnt <= prime_cnt + PCW'(1);
        end
        ST_TRACK: begin
          // A new illegal jump overrides a simultaneous err_clr.
          if (is_bad) begin
            err <= 1'b1;
          end else if (!load_en && (is_up || is_down)) begin
            count_out <= is_up ? count_out + WIDTH'(1) : count_out - WIDTH'(1);
            dir       <= is_up;
            step      <= 1'b1;
          end
        end
        default: state <= ST_PRIME;
      endcase
      if (load_en) count_out <= data_in;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder_counter.sv
// Directed bench for quadrature_decoder_counter (WIDTH=8, SYNC_STAGES=2).
module tb_quadrature_decoder_counter;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       quad_a;
  logic       quad_b;
  logic       load_en;
  logic [7:0] data_in;
  logic       err_clr;
  logic [7:0] count_out;
  logic       dir;
  logic       step;
  logic       err;

  int checks = 0;
  int errors = 0;

  quadrature_decoder_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .load_en   (load_en),
    .data_in   (data_in),
    .err_clr   (err_clr),
    .count_out (count_out),
    .dir       (dir),
    .step      (step),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ph(input logic [1:0] ph);
    {quad_a, quad_b} = ph;
  endtask

  task automatic do_reset(input logic [1:0] ph);
    set_ph(ph);
    load_en = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    reset   = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(12);
  endtask

  task automatic test_reset;
    set_ph(2'b11);
    load_en = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    reset   = 1'b1;
    tick(2);
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL rst_count: got %0h expected 0", count_out); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rst_dir: got %0b expected 1", dir); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL rst_step: got %0b expected 0", step); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b expected 0", err); end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checks++;
      if ({err, step} !== 2'b00) begin
        errors++; $display("FAIL prime_quiet[%0d]: got err/step %b expected 00", i, {err, step});
      end
    end
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL prime_count: got %0h expected 0", count_out); end
  endtask

  task automatic test_up;
    logic [1:0] seq [4];
    logic [7:0] exp_cnt;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    exp_cnt = 8'h00;
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      set_ph(seq[i]);
      tick(LAT - 1);
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL up_early_step[%0d]: got %0b expected 0", i, step); end
      checks++; if (count_out !== exp_cnt) begin errors++; $display("FAIL up_early_count[%0d]: got %0h expected %0h", i, count_out, exp_cnt); end
      tick(1);
      exp_cnt = exp_cnt + 8'h01;
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL up_step[%0d]: got %0b expected 1", i, step); end
      checks++; if (count_out !== exp_cnt) begin errors++; $display("FAIL up_count[%0d]: got %0h expected %0h", i, count_out, exp_cnt); end
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL up_dir[%0d]: got %0b expected 1", i, dir); end
      tick(1);
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL up_step_width[%0d]: got %0b expected 0", i, step); end
      tick(10 - LAT - 1);
    end
  endtask

  task automatic test_down;
    logic [1:0] seq [5];
    logic [7:0] exp_cnt [5];
    seq     = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    load_en = 1'b1;
    data_in = 8'd3;
    tick(1);
    load_en = 1'b0;
    checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL down_load: got %0h expected 3", count_out); end
    tick(3);
    for (int i = 0; i < 5; i++) begin
      set_ph(seq[i]);
      tick(LAT);
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL down_step[%0d]: got %0b expected 1", i, step); end
      checks++; if (count_out !== exp_cnt[i]) begin errors++; $display("FAIL down_count[%0d]: got %0h expected %0h", i, count_out, exp_cnt[i]); end
      checks++; if (dir !== 1'b0) begin errors++; $display("FAIL down_dir[%0d]: got %0b expected 0", i, dir); end
      tick(1);
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL down_step_width[%0d]: got %0b expected 0", i, step); end
      tick(10 - LAT - 1);
    end
  endtask

  task automatic test_load_priority;
    // Phase is 01, dir is 0: 01->00 is an up step decoded in the load cycle.
    set_ph(2'b00);
    tick(LAT - 1);
    load_en = 1'b1;
    data_in = 8'hA5;
    tick(1);
    load_en = 1'b0;
    checks++; if (count_out !== 8'hA5) begin errors++; $display("FAIL load_count: got %0h expected a5", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL load_step: got %0b expected 0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL load_dir: got %0b expected 0", dir); end
    tick(1);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL load_step_after: got %0b expected 0", step); end
    tick(5);
    set_ph(2'b10);
    tick(LAT);
    checks++; if (count_out !== 8'hA6) begin errors++; $display("FAIL load_next_count: got %0h expected a6", count_out); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL load_next_step: got %0b expected 1", step); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL load_next_dir: got %0b expected 1", dir); end
    tick(5);
  endtask

  task automatic test_err;
    do_reset(2'b00);
    set_ph(2'b11);
    tick(LAT);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", err); end
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL err_count: got %0h expected 0", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL err_step: got %0b expected 0", step); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL err_dir: got %0b expected 1", dir); end
    tick(3);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", err); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b expected 0", err); end
    // 11 -> 01 -> 00 -> 10 are three up steps.
    set_ph(2'b01);
    tick(LAT + 4);
    set_ph(2'b00);
    tick(LAT + 4);
    set_ph(2'b10);
    tick(LAT + 4);
    checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL err_recount: got %0h expected 3", count_out); end
    set_ph(2'b01);
    tick(LAT - 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %0b expected 1", err); end
    checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL err_jump_count: got %0h expected 3", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL err_jump_step: got %0b expected 0", step); end
  endtask

  task automatic test_reset_mid;
    do_reset(2'b00);
    set_ph(2'b10);
    tick(LAT);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL mid_pre_step: got %0b expected 1", step); end
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL mid_pre_count: got %0h expected 1", count_out); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL mid_async_count: got %0h expected 0", count_out); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL mid_async_step: got %0b expected 0", step); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL mid_async_dir: got %0b expected 1", dir); end
    tick(2);
    reset = 1'b0;
    tick(12);
    checks++; if ({err, count_out} !== 9'h000) begin errors++; $display("FAIL mid_resume_idle: got err/count %0h expected 0", {err, count_out}); end
    set_ph(2'b11);
    tick(LAT);
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL mid_resume_count: got %0h expected 1", count_out); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL mid_resume_step: got %0b expected 1", step); end
  endtask

`ifdef QDEC_GLITCH_FILTER_EN
  task automatic test_glitch;
    do_reset(2'b00);
    set_ph(2'b10);
    tick(2);
    set_ph(2'b00);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++;
      if ({err, step} !== 2'b00) begin
        errors++; $display("FAIL glitch_quiet[%0d]: got err/step %b expected 00", i, {err, step});
      end
    end
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL glitch_count: got %0h expected 0", count_out); end
    set_ph(2'b10);
    tick(LAT - 1);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL glitch_early_step: got %0b expected 0", step); end
    tick(1);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL glitch_held_step: got %0b expected 1", step); end
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL glitch_held_count: got %0h expected 1", count_out); end
  endtask
`endif

  initial begin
    test_reset;
    test_up;
    test_down;
    test_load_priority;
    test_err;
    test_reset_mid;
`ifdef QDEC_GLITCH_FILTER_EN
    test_glitch;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
